// File: rtl/hpdcache_mem_responder_pkg.sv
// Shared types for the HPDcache memory responder: request/response payloads,
// FSM state encoding and small elaboration-time helpers.
package hpdcache_mem_responder_pkg;

   localparam int unsigned MEM_ADDR_W = 56;
   localparam int unsigned MEM_ID_W   = 7;
   localparam int unsigned MEM_DATA_W = 512;
   localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;
   localparam int unsigned MEM_LEN_W  = 8;

   typedef enum logic [1:0] {
      MEM_READ   = 2'd0,
      MEM_WRITE  = 2'd1,
      MEM_ATOMIC = 2'd2
   } mem_command_e;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_LEN_W-1:0]  len;
      logic [2:0]            size;
      logic [MEM_ID_W-1:0]   id;
      mem_command_e          command;
      logic [3:0]            atomic;
      logic                  cacheable;
   } mem_req_t;

   typedef struct packed {
      logic [MEM_DATA_W-1:0] data;
      logic [MEM_BE_W-1:0]   be;
      logic                  last;
   } mem_req_w_t;

   typedef struct packed {
      logic                  error;
      logic [MEM_ID_W-1:0]   id;
      logic [MEM_DATA_W-1:0] data;
      logic                  last;
   } mem_resp_r_t;

   typedef struct packed {
      logic                is_atomic;
      logic                error;
      logic [MEM_ID_W-1:0] id;
   } mem_resp_w_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_BURST,
      ST_WR_DATA,
      ST_WR_RESP
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

   // Only plain reads on the read channel and plain writes on the write
   // channel are served; anything else completes with an error.
   function automatic logic cmd_illegal(input mem_command_e cmd,
                                        input logic [3:0]   atomic,
                                        input logic         is_write);
      return (cmd != (is_write ? MEM_WRITE : MEM_READ)) || (atomic != 4'd0);
   endfunction

endpackage

// File: rtl/hpdcache_mem_responder_ram.sv
// Line-wide storage for the memory responder: combinational read port and
// synchronous write port with per-byte enables.
module hpdcache_mem_responder_ram
   import hpdcache_mem_responder_pkg::*;
#(
   parameter int unsigned DepthLines = 256,
   parameter int unsigned DataWidth  = 512,
   parameter int unsigned IdxW       = clog2(DepthLines)
) (
   input  logic                   clk_i,
   input  logic                   we,
   input  logic [IdxW-1:0]        widx,
   input  logic [DataWidth-1:0]   wdata,
   input  logic [DataWidth/8-1:0] wbe,
   input  logic [IdxW-1:0]        ridx,
   output logic [DataWidth-1:0]   rdata
);

   logic [DataWidth-1:0] mem [DepthLines];

   // NOTE: the array has no reset; clearing every line would turn it into
   // flops and defeat RAM inference, and contents are undefined until written.
   always_ff @(posedge clk_i) begin
      if (we) begin
         for (int b = 0; b < DataWidth / 8; b++) begin
            if (wbe[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/hpdcache_mem_responder.sv
// Single-transaction memory slave for the HPDcache memory interface.
// Optional fixed read latency: define HPDCACHE_MEM_RESPONDER_LATENCY_EN.
module hpdcache_mem_responder
   import hpdcache_mem_responder_pkg::*;
#(
   parameter int unsigned MemAddrWidth = MEM_ADDR_W,
   parameter int unsigned MemIdWidth   = MEM_ID_W,
   parameter int unsigned MemDataWidth = MEM_DATA_W,
   parameter int unsigned DepthLines   = 256,
   parameter int unsigned ReadLatency  = 4,
   parameter type hpdcache_mem_req_t    = mem_req_t,
   parameter type hpdcache_mem_req_w_t  = mem_req_w_t,
   parameter type hpdcache_mem_resp_r_t = mem_resp_r_t,
   parameter type hpdcache_mem_resp_w_t = mem_resp_w_t
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 mem_req_read_valid_i,
   output logic                 mem_req_read_ready_o,
   input  hpdcache_mem_req_t    mem_req_read_i,
   output logic                 mem_resp_read_valid_o,
   input  logic                 mem_resp_read_ready_i,
   output hpdcache_mem_resp_r_t mem_resp_read_o,
   input  logic                 mem_req_write_valid_i,
   output logic                 mem_req_write_ready_o,
   input  hpdcache_mem_req_t    mem_req_write_i,
   input  logic                 mem_req_write_data_valid_i,
   output logic                 mem_req_write_data_ready_o,
   input  hpdcache_mem_req_w_t  mem_req_write_data_i,
   output logic                 mem_resp_write_valid_o,
   input  logic                 mem_resp_write_ready_i,
   output hpdcache_mem_resp_w_t mem_resp_write_o
);

   localparam int unsigned IdxW = clog2(DepthLines);
   localparam int unsigned OffW = clog2(MemDataWidth / 8);

   state_e                  state_q, state_d;
   logic                    rr_wr_q, rr_wr_d;   // 1: write side wins a tie
   logic [MemIdWidth-1:0]   id_q, id_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [MEM_LEN_W-1:0]    rem_q, rem_d;
   logic                    err_q, err_d;

`ifdef HPDCACHE_MEM_RESPONDER_LATENCY_EN
   localparam int unsigned LatW = (ReadLatency > 1) ? clog2(ReadLatency + 1) : 1;
   logic [LatW-1:0]         lat_q, lat_d;
`endif

   logic [MemAddrWidth-1:0] rd_addr, wr_addr;
   logic                    grant_rd, grant_wr;
   logic                    ram_we;
   logic [MemDataWidth-1:0] ram_rdata;
   logic                    unused_fields;

   assign rd_addr = mem_req_read_i.addr;
   assign wr_addr = mem_req_write_i.addr;
   assign unused_fields = ^{mem_req_read_i, mem_req_write_i, rd_addr, wr_addr,
                            mem_req_write_data_i.last};

   assign grant_rd = mem_req_read_valid_i  & (~mem_req_write_valid_i | ~rr_wr_q);
   assign grant_wr = mem_req_write_valid_i & (~mem_req_read_valid_i  |  rr_wr_q);

   // NOTE: every signal driven here gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      rr_wr_d = rr_wr_q;
      id_d    = id_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      err_d   = err_q;
`ifdef HPDCACHE_MEM_RESPONDER_LATENCY_EN
      lat_d   = lat_q;
`endif
      mem_req_read_ready_o       = 1'b0;
      mem_req_write_ready_o      = 1'b0;
      mem_req_write_data_ready_o = 1'b0;
      ram_we                     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Readies are masked while reset is held so nothing is accepted.
            mem_req_read_ready_o  = grant_rd & ~rst_i;
            mem_req_write_ready_o = grant_wr & ~rst_i;
            if (mem_req_read_ready_o) begin
               rr_wr_d = ~rr_wr_q;
               id_d    = mem_req_read_i.id;
               idx_d   = rd_addr[OffW +: IdxW];
               rem_d   = mem_req_read_i.len;
               err_d   = cmd_illegal(mem_req_read_i.command, mem_req_read_i.atomic, 1'b0);
`ifdef HPDCACHE_MEM_RESPONDER_LATENCY_EN
               if (ReadLatency != 0) begin
                  state_d = ST_RD_WAIT;
                  lat_d   = LatW'(ReadLatency);
               end else begin
                  state_d = ST_RD_BURST;
               end
`else
               state_d = ST_RD_BURST;
`endif
            end else if (mem_req_write_ready_o) begin
               rr_wr_d = ~rr_wr_q;
               id_d    = mem_req_write_i.id;
               idx_d   = wr_addr[OffW +: IdxW];
               rem_d   = mem_req_write_i.len;
               err_d   = cmd_illegal(mem_req_write_i.command, mem_req_write_i.atomic, 1'b1);
               state_d = ST_WR_DATA;
            end
         end

`ifdef HPDCACHE_MEM_RESPONDER_LATENCY_EN
         ST_RD_WAIT: begin
            lat_d = lat_q - LatW'(1);
            if (lat_q == LatW'(1)) state_d = ST_RD_BURST;
         end
`endif

         ST_RD_BURST: begin
            if (mem_resp_read_ready_i) begin
               if (rem_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + IdxW'(1);
                  rem_d = rem_q - MEM_LEN_W'(1);
               end
            end
         end

         ST_WR_DATA: begin
            mem_req_write_data_ready_o = 1'b1;
            if (mem_req_write_data_valid_i) begin
               ram_we = ~err_q;
               if (rem_q == '0) begin
                  state_d = ST_WR_RESP;
               end else begin
                  idx_d = idx_q + IdxW'(1);
                  rem_d = rem_q - MEM_LEN_W'(1);
               end
            end
         end

         ST_WR_RESP: begin
            if (mem_resp_write_ready_i) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         rr_wr_q <= 1'b0;
         id_q    <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
`ifdef HPDCACHE_MEM_RESPONDER_LATENCY_EN
         lat_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_wr_q <= rr_wr_d;
         id_q    <= id_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
`ifdef HPDCACHE_MEM_RESPONDER_LATENCY_EN
         lat_q   <= lat_d;
`endif
      end
   end

   assign mem_resp_read_valid_o  = (state_q == ST_RD_BURST);
   assign mem_resp_write_valid_o = (state_q == ST_WR_RESP);

   // Payloads stay zero outside their response state.
   always_comb begin
      mem_resp_read_o = '0;
      if (state_q == ST_RD_BURST) begin
         mem_resp_read_o.error = err_q;
         mem_resp_read_o.id    = id_q;
         mem_resp_read_o.data  = err_q ? '0 : ram_rdata;
         mem_resp_read_o.last  = (rem_q == '0);
      end
   end

   always_comb begin
      mem_resp_write_o = '0;
      if (state_q == ST_WR_RESP) begin
         mem_resp_write_o.is_atomic = 1'b0;
         mem_resp_write_o.error     = err_q;
         mem_resp_write_o.id        = id_q;
      end
   end

   hpdcache_mem_responder_ram #(
      .DepthLines (DepthLines),
      .DataWidth  (MemDataWidth),
      .IdxW       (IdxW)
   ) u_ram (
      .clk_i (clk_i),
      .we    (ram_we),
      .widx  (idx_q),
      .wdata (mem_req_write_data_i.data),
      .wbe   (mem_req_write_data_i.be),
      .ridx  (idx_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_hpdcache_mem_responder.sv
// Directed bench for hpdcache_mem_responder with hand-computed expectations.
module tb_hpdcache_mem_responder;
   import hpdcache_mem_responder_pkg::*;

`ifdef HPDCACHE_MEM_RESPONDER_LATENCY_EN
   localparam int EXP_LAT = 4;
`else
   localparam int EXP_LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_valid, rd_ready, rresp_valid, rresp_ready;
   logic        wr_valid, wr_ready, wdata_valid, wdata_ready, wresp_valid, wresp_ready;
   mem_req_t    rd_req, wr_req;
   mem_req_w_t  wdata;
   mem_resp_r_t rresp;
   mem_resp_w_t wresp;

   logic [511:0] exp_beat [8];
   logic [511:0] wr_beat  [8];

   int n_pass  = 0;
   int n_total = 0;

   hpdcache_mem_responder #(
      .MemAddrWidth (56),
      .MemIdWidth   (7),
      .MemDataWidth (512),
      .DepthLines   (256),
      .ReadLatency  (4)
   ) dut (
      .clk_i                      (clk),
      .rst_i                      (rst),
      .mem_req_read_valid_i       (rd_valid),
      .mem_req_read_ready_o       (rd_ready),
      .mem_req_read_i             (rd_req),
      .mem_resp_read_valid_o      (rresp_valid),
      .mem_resp_read_ready_i      (rresp_ready),
      .mem_resp_read_o            (rresp),
      .mem_req_write_valid_i      (wr_valid),
      .mem_req_write_ready_o      (wr_ready),
      .mem_req_write_i            (wr_req),
      .mem_req_write_data_valid_i (wdata_valid),
      .mem_req_write_data_ready_o (wdata_ready),
      .mem_req_write_data_i       (wdata),
      .mem_resp_write_valid_o     (wresp_valid),
      .mem_resp_write_ready_i     (wresp_ready),
      .mem_resp_write_o           (wresp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic mem_req_t mk_req(input logic [55:0] addr, input logic [7:0] len,
                                       input logic [6:0] id, input mem_command_e cmd,
                                       input logic [3:0] atom);
      mem_req_t r;
      r = '0;
      r.addr = addr; r.len = len; r.size = 3'd6; r.id = id;
      r.command = cmd; r.atomic = atom; r.cacheable = 1'b1;
      return r;
   endfunction

   // Handshake a read request and wait for the first beat; ends at the
   // negedge where the first beat is visible.
   task automatic rd_request(input mem_req_t req);
      int n, lat;
      @(negedge clk);
      rd_req = req; rd_valid = 1'b1;
      #1; n = 0;
      while (!rd_ready && n < 50) begin @(negedge clk); #1; n++; end
      check("rd_req_ready", rd_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      rd_valid = 1'b0;
      lat = 0;
      while (!rresp_valid && lat < 50) begin @(negedge clk); lat++; end
      check("rd_first_beat_latency", lat, EXP_LAT);
   endtask

   task automatic do_read(input mem_req_t req, input logic exp_err);
      rd_request(req);
      for (int i = 0; i <= int'(req.len); i++) begin
         check($sformatf("rd_valid[%0d]", i), rresp_valid, 1'b1);
         check($sformatf("rd_data[%0d]", i), rresp.data, exp_beat[i]);
         check($sformatf("rd_last[%0d]", i), rresp.last, i == int'(req.len));
         check($sformatf("rd_id[%0d]", i), rresp.id, req.id);
         check($sformatf("rd_err[%0d]", i), rresp.error, exp_err);
         @(negedge clk);
      end
      check("rd_done_idle", rresp_valid, 1'b0);
   endtask

   task automatic do_write(input mem_req_t req, input logic [63:0] be, input logic exp_err);
      int n;
      @(negedge clk);
      wr_req = req; wr_valid = 1'b1;
      #1; n = 0;
      while (!wr_ready && n < 50) begin @(negedge clk); #1; n++; end
      check("wr_req_ready", wr_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      for (int i = 0; i <= int'(req.len); i++) begin
         wdata.data = wr_beat[i]; wdata.be = be; wdata.last = 1'b0;
         wdata_valid = 1'b1;
         #1; n = 0;
         while (!wdata_ready && n < 50) begin @(negedge clk); #1; n++; end
         check($sformatf("wr_data_ready[%0d]", i), wdata_ready, 1'b1);
         @(posedge clk);
         @(negedge clk);
      end
      wdata_valid = 1'b0;
      n = 0;
      while (!wresp_valid && n < 50) begin @(negedge clk); n++; end
      check("wr_ack_valid", wresp_valid, 1'b1);
      check("wr_ack_id", wresp.id, req.id);
      check("wr_ack_err", wresp.error, exp_err);
      check("wr_ack_is_atomic", wresp.is_atomic, 1'b0);
      @(negedge clk);
      check("wr_ack_done", wresp_valid, 1'b0);
   endtask

   initial begin
      int   grants, cyc, n;
      logic seq [4];

      rst = 1'b1;
      rd_valid = 1'b0; wr_valid = 1'b0; wdata_valid = 1'b0;
      rresp_ready = 1'b1; wresp_ready = 1'b1;
      rd_req = '0; wr_req = '0; wdata = '0;

      // Reset state, with both requests pending to exercise ready masking
      repeat (2) @(negedge clk);
      rd_valid = 1'b1; wr_valid = 1'b1;
      #1;
      check("rst_rd_ready", rd_ready, 1'b0);
      check("rst_wr_ready", wr_ready, 1'b0);
      check("rst_rresp_valid", rresp_valid, 1'b0);
      check("rst_wresp_valid", wresp_valid, 1'b0);
      check("rst_wdata_ready", wdata_ready, 1'b0);
      check("rst_rresp_payload", rresp, '0);
      check("rst_wresp_payload", wresp, '0);
      rd_valid = 1'b0; wr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Single-beat write then read of line 1
      wr_beat[0] = {64{8'hA5}};
      do_write(mk_req(56'h40, 8'd0, 7'd3, MEM_WRITE, 4'h0), {64{1'b1}}, 1'b0);
      exp_beat[0] = {64{8'hA5}};
      do_read(mk_req(56'h40, 8'd0, 7'd5, MEM_READ, 4'h0), 1'b0);

      // Four-beat burst to lines 0..3
      for (int i = 0; i < 4; i++) wr_beat[i] = 512'(i + 1);
      do_write(mk_req(56'h0, 8'd3, 7'd9, MEM_WRITE, 4'h0), {64{1'b1}}, 1'b0);
      for (int i = 0; i < 4; i++) exp_beat[i] = 512'(i + 1);
      do_read(mk_req(56'h0, 8'd3, 7'd10, MEM_READ, 4'h0), 1'b0);

      // Byte enable: only byte 1 of line 1 (holding 2) is overwritten
      wr_beat[0] = {64{8'hFF}};
      do_write(mk_req(56'h40, 8'd0, 7'd11, MEM_WRITE, 4'h0), 64'h2, 1'b0);
      exp_beat[0] = 512'hFF02;
      do_read(mk_req(56'h40, 8'd0, 7'd12, MEM_READ, 4'h0), 1'b0);

      // Wrap from line 255 to line 0; 0x4000 aliases line 0
      wr_beat[0] = 512'h11; wr_beat[1] = 512'h22;
      do_write(mk_req(56'h3FC0, 8'd1, 7'd20, MEM_WRITE, 4'h0), {64{1'b1}}, 1'b0);
      exp_beat[0] = 512'h11; exp_beat[1] = 512'h22;
      do_read(mk_req(56'h3FC0, 8'd1, 7'd21, MEM_READ, 4'h0), 1'b0);
      exp_beat[0] = 512'h22;
      do_read(mk_req(56'h4000, 8'd0, 7'd22, MEM_READ, 4'h0), 1'b0);

      // Atomic write is consumed but leaves line 2 (holding 3) untouched
      wr_beat[0] = {64{8'hFF}};
      do_write(mk_req(56'h80, 8'd0, 7'd30, MEM_ATOMIC, 4'h1), {64{1'b1}}, 1'b1);
      exp_beat[0] = 512'h3;
      do_read(mk_req(56'h80, 8'd0, 7'd31, MEM_READ, 4'h0), 1'b0);

      // Atomic read: two zero-data error beats
      exp_beat[0] = '0; exp_beat[1] = '0;
      do_read(mk_req(56'h0, 8'd1, 7'd32, MEM_ATOMIC, 4'h2), 1'b1);

      // Back-pressure mid-burst, then reset mid-burst
      rd_request(mk_req(56'h0, 8'd3, 7'd40, MEM_READ, 4'h0));
      check("stall_beat0", rresp.data, 512'h22);
      @(negedge clk);
      rresp_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_valid", rresp_valid, 1'b1);
         check("stall_data", rresp.data, 512'hFF02);
         check("stall_last", rresp.last, 1'b0);
         check("stall_id", rresp.id, 7'd40);
      end
      rresp_ready = 1'b1;
      @(negedge clk);
      check("stall_beat2", rresp.data, 512'h3);
      rst = 1'b1;
      #1;
      check("rst_mid_rvalid", rresp_valid, 1'b0);
      check("rst_mid_wvalid", wresp_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rresp_valid) n++;
      end
      check("rst_no_more_beats", n, 0);

      // Round-robin with both requests held valid
      @(negedge clk);
      rd_req = mk_req(56'hC0, 8'd0, 7'd1, MEM_READ, 4'h0);
      wr_req = mk_req(56'h100, 8'd0, 7'd2, MEM_WRITE, 4'h0);
      wdata.data = 512'h77; wdata.be = {64{1'b1}}; wdata.last = 1'b1;
      rd_valid = 1'b1; wr_valid = 1'b1; wdata_valid = 1'b1;
      grants = 0; cyc = 0;
      while (grants < 4 && cyc < 100) begin
         #1;
         if (rd_ready || wr_ready) begin
            check("arb_one_ready", rd_ready & wr_ready, 1'b0);
            seq[grants] = wr_ready;
            grants++;
         end
         @(negedge clk);
         cyc++;
      end
      rd_valid = 1'b0; wr_valid = 1'b0;
      check("arb_grant_count", grants, 4);
      for (int k = 0; k < 4; k++) check($sformatf("arb_grant[%0d]", k), seq[k], (k % 2) == 1);
      n = 0;
      while (!wresp_valid && n < 50) begin @(negedge clk); n++; end
      check("arb_wr_ack", wresp_valid, 1'b1);
      @(negedge clk);
      wdata_valid = 1'b0;
      exp_beat[0] = 512'h77;
      do_read(mk_req(56'h100, 8'd0, 7'd3, MEM_READ, 4'h0), 1'b0);
      exp_beat[0] = 512'h4;
      do_read(mk_req(56'hC0, 8'd0, 7'd4, MEM_READ, 4'h0), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hpdcache_mem_responder.md
Name: hpdcache_mem_responder

Overview:
- Memory-side slave for the HPDcache memory interface: accepts read and write requests, serves them from an internal byte-enabled line-wide storage array, and returns read data beats and write acknowledgements.
- Sits between the cache's mem_req_*/mem_resp_* channels and nothing else.
- Used as a synthesizable on-chip memory for the synthesis wrapper and as a self-contained responder for unit benches.
- Serves one transaction at a time.

Parameters:
- MemAddrWidth, 56, byte address width of mem_req addr.
- MemIdWidth, 7, transaction ID width.
- MemDataWidth, 512, beat width in bits; bytes per beat B = MemDataWidth/8.
- DepthLines, 256, storage depth in beats; power of two.
- ReadLatency, 4, extra idle cycles before the first read beat; used only with the optional feature.
- The request and response types are type parameters built with the HPDCACHE_DECL_MEM_* macros from the widths above.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- mem_req_read_valid_i  in  1  read request valid
- mem_req_read_ready_o  out  1  read request ready
- mem_req_read_i  in  hpdcache_mem_req_t  read request (addr, len, size, id, command, atomic, cacheable)
- mem_resp_read_valid_o  out  1  read beat valid
- mem_resp_read_ready_i  in  1  read beat ready
- mem_resp_read_o  out  hpdcache_mem_resp_r_t  read beat (error, id, data, last)
- mem_req_write_valid_i  in  1  write request valid
- mem_req_write_ready_o  out  1  write request ready
- mem_req_write_i  in  hpdcache_mem_req_t  write request
- mem_req_write_data_valid_i  in  1  write data valid
- mem_req_write_data_ready_o  out  1  write data ready
- mem_req_write_data_i  in  hpdcache_mem_req_w_t  write data (data, be, last)
- mem_resp_write_valid_o  out  1  write ack valid
- mem_resp_write_ready_i  in  1  write ack ready
- mem_resp_write_o  out  hpdcache_mem_resp_w_t  write ack (is_atomic, error, id)

Behaviour:
- Interface fixed: single clock clk_i; asynchronous active-high reset rst_i.
- Reset: state IDLE, all valid/ready outputs 0, response payloads 0, arbitration pointer = read. Storage contents are not reset.
- Reset mid-transaction aborts it; no response is produced for the aborted transaction.
- FSM states:
  - IDLE: readies computed per the arbitration rule below.
  - RD_WAIT: only with the optional feature.
  - RD_BURST
  - WR_DATA
  - WR_RESP
- Arbitration in IDLE:
  - Only read valid -> read ready = 1.
  - Only write valid -> write ready = 1.
  - Both valid -> grant the side indicated by the pointer; the pointer flips after each grant (round-robin).
  - Exactly one request ready is high per cycle.
- Request capture: on handshake, register id, beat index = addr[log2(B) +: log2(DepthLines)], remaining = len, err = (command != READ/WRITE) | atomic.
- Higher address bits are ignored; addresses alias modulo DepthLines.
- Read path:
  - Accept in cycle T; first beat valid at T+1.
  - Each beat: data = storage[index] (0 if err), error = err, id = captured id, last = (remaining == 0).
  - A beat is held stable until mem_resp_read_ready_i; on handshake, index increments modulo DepthLines (wraps DepthLines-1 -> 0) and remaining decrements.
  - After the last beat handshake -> IDLE; the next request may be accepted in that same IDLE cycle.
- Write path:
  - Accept in cycle T -> WR_DATA from T+1 with write data ready = 1.
  - Each data handshake writes storage[index] under be, unless err. Index and remaining update as for reads.
  - The incoming last flag is ignored; the beat count is len+1.
  - After len+1 beats -> WR_RESP: valid = 1, id, error = err, is_atomic = 0. Hold until ready, then IDLE.
- Storage read is combinational on index; writes are synchronous.
- A write followed by a read to the same line returns the new data, since transactions are serialised.
- mem_resp_*_ready_i deasserted indefinitely: the FSM stalls, with no data loss.

Optional Feature:
- HPDCACHE_MEM_RESPONDER_LATENCY_EN defined:
  - After read acceptance the FSM enters RD_WAIT with a down-counter loaded with ReadLatency; the first beat is valid at T+1+ReadLatency.
  - ReadLatency = 0 behaves as undefined.
  - Subsequent beats are unaffected.
- Undefined: RD_WAIT and the counter are not built; first beat at T+1.

Decomposition:
- Package hpdcache_mem_responder_pkg: FSM state enum, the beat-index width function clog2(DepthLines), and the command-legality helper.
- One sub-module, hpdcache_mem_responder_ram: DepthLines x MemDataWidth array with per-byte write enable, combinational read port and synchronous write port.

Test Plan:
- Reset release, read addr 0x40 len 0 id 5 with storage pre-written 0xA5..: one beat at T+1, id 5, last 1, error 0, data matches; then IDLE.
- Write addr 0x0 len 3 with be all-ones and data 1,2,3,4, then read addr 0x0 len 3: beats 1,2,3,4 in order, last only on beat 4; write ack id matches, error 0.
- Write at line DepthLines-1 with len 1: second beat lands in line 0; a read with len 1 from the same address returns both beats.
- Simultaneous read and write valid for 4 consecutive requests: grants alternate R,W,R,W; one request ready per cycle.
- Atomic write command: data beats consumed, storage unchanged (check by readback), ack error 1. Atomic read of len 1: 2 beats, data 0, error 1.
- mem_resp_read_ready_i held 0 for 10 cycles mid-burst: beat payload stable throughout; assert rst_i mid-burst -> all valids 0 immediately and no further beats.
- With HPDCACHE_MEM_RESPONDER_LATENCY_EN defined and ReadLatency=4: first beat at T+5.
